// File: rtl/bcd_counter_display.sv
// Multi-digit BCD up/down counter with a multiplexed seven-segment display.
// Optional macro LEADING_ZERO_BLANK_EN blanks leading zero digits above digit 0.
module bcd_counter_display #(
    parameter int DIGITS   = 4,
    parameter int TICK_DIV = 50000000,
    parameter int SCAN_DIV = 50000,
    parameter int SATURATE = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable_i,
    input  logic                  dir_i,
    input  logic                  clear_i,
    input  logic                  load_i,
    input  logic [4*DIGITS-1:0]   load_value_i,
    output logic [4*DIGITS-1:0]   count_o,
    output logic                  wrap_o,
    output logic [6:0]            seg_o,
    output logic [DIGITS-1:0]     an_o
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);
    localparam logic [SW-1:0] SCAN_MAX  = SW'(SCAN_DIV - 1);
    localparam logic [IW-1:0] IDX_MAX   = IW'(DIGITS - 1);

    logic [PW-1:0]         presc;
    logic [PW-1:0]         presc_nxt;
    logic [SW-1:0]         scan_cnt;
    logic [SW-1:0]         scan_cnt_nxt;
    logic [IW-1:0]         idx;
    logic [IW-1:0]         idx_nxt;
    logic [4*DIGITS-1:0]   count_nxt;
    logic [4*DIGITS-1:0]   cnt_up;
    logic [4*DIGITS-1:0]   cnt_dn;
    logic [4*DIGITS-1:0]   load_clamped;
    logic                  wrap_nxt;
    logic                  tick;
    logic                  all9;
    logic                  all0;
    logic                  carry;
    logic                  borrow;
    logic [3:0]            dig;
    logic [3:0]            sel_dig;
    logic                  blank;
    logic [6:0]            seg_nxt;
    logic [DIGITS-1:0]     an_nxt;

    function automatic logic [6:0] glyph(input logic [3:0] d);
        logic [6:0] g;
        case (d)
            4'd0:    g = 7'b1111110;
            4'd1:    g = 7'b0110000;
            4'd2:    g = 7'b1101101;
            4'd3:    g = 7'b1111001;
            4'd4:    g = 7'b0110011;
            4'd5:    g = 7'b1011011;
            4'd6:    g = 7'b1011111;
            4'd7:    g = 7'b1110000;
            4'd8:    g = 7'b1111111;
            4'd9:    g = 7'b1111011;
            default: g = 7'b0000000;
        endcase
        return g;
    endfunction

    assign tick = enable_i && (presc == PRESC_MAX);

    // Ripple BCD increment/decrement candidates and limit detection
    always_comb begin
        cnt_up = count_o;
        cnt_dn = count_o;
        carry  = 1'b1;
        borrow = 1'b1;
        all9   = 1'b1;
        all0   = 1'b1;
        dig    = 4'd0;
        for (int k = 0; k < DIGITS; k++) begin
            dig = count_o[4*k +: 4];
            if (dig != 4'd9) all9 = 1'b0;
            if (dig != 4'd0) all0 = 1'b0;
            if (carry) begin
                if (dig == 4'd9) begin
                    cnt_up[4*k +: 4] = 4'd0;
                end else begin
                    cnt_up[4*k +: 4] = dig + 4'd1;
                    carry = 1'b0;
                end
            end
            if (borrow) begin
                if (dig == 4'd0) begin
                    cnt_dn[4*k +: 4] = 4'd9;
                end else begin
                    cnt_dn[4*k +: 4] = dig - 4'd1;
                    borrow = 1'b0;
                end
            end
        end
    end

    // Per-digit clamp of the load value to 9
    always_comb begin
        load_clamped = load_value_i;
        for (int k = 0; k < DIGITS; k++) begin
            if (load_value_i[4*k +: 4] > 4'd9) load_clamped[4*k +: 4] = 4'd9;
        end
    end

    // Count/prescaler next state: clear beats load beats tick
    always_comb begin
        count_nxt = count_o;
        presc_nxt = presc;
        wrap_nxt  = 1'b0;
        if (clear_i) begin
            count_nxt = '0;
            presc_nxt = '0;
        end else if (load_i) begin
            count_nxt = load_clamped;
            presc_nxt = '0;
        end else if (tick) begin
            presc_nxt = '0;
            if (dir_i) begin
                if (SATURATE == 0 || !all9) count_nxt = cnt_up;
                wrap_nxt = all9 && (SATURATE == 0);
            end else begin
                if (SATURATE == 0 || !all0) count_nxt = cnt_dn;
                wrap_nxt = all0 && (SATURATE == 0);
            end
        end else if (enable_i) begin
            presc_nxt = presc + PW'(1);
        end
    end

    // Scan divider and digit index, free running
    always_comb begin
        scan_cnt_nxt = scan_cnt + SW'(1);
        idx_nxt      = idx;
        if (scan_cnt == SCAN_MAX) begin
            scan_cnt_nxt = '0;
            idx_nxt = (idx == IDX_MAX) ? '0 : idx + IW'(1);
        end
    end

    // Decode the digit selected next cycle from the count of next cycle
    always_comb begin
        sel_dig = count_nxt[4*idx_nxt +: 4];
        an_nxt  = DIGITS'(1) << idx_nxt;
        blank   = 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
        blank = (idx_nxt != '0);
        for (int k = 0; k < DIGITS; k++) begin
            if (k >= int'(idx_nxt) && count_nxt[4*k +: 4] != 4'd0) blank = 1'b0;
        end
`endif
        seg_nxt = blank ? 7'b0000000 : glyph(sel_dig);
    end

    // State registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_o  <= '0;
            presc    <= '0;
            wrap_o   <= 1'b0;
            scan_cnt <= '0;
            idx      <= '0;
            an_o     <= DIGITS'(1);
            seg_o    <= 7'b1111110;
        end else begin
            count_o  <= count_nxt;
            presc    <= presc_nxt;
            wrap_o   <= wrap_nxt;
            scan_cnt <= scan_cnt_nxt;
            idx      <= idx_nxt;
            an_o     <= an_nxt;
            seg_o    <= seg_nxt;
        end
    end

endmodule

// File: tb/tb_bcd_counter_display.sv
// Directed bench for bcd_counter_display, DIGITS=2 TICK_DIV=1 SCAN_DIV=2.
// Instance a wraps, instance b saturates; both share stimulus.
module tb_bcd_counter_display;

    localparam int SCAN_DIV = 2;

    logic       clk;
    logic       rst;
    logic       enable_i;
    logic       dir_i;
    logic       clear_i;
    logic       load_i;
    logic [7:0] load_value_i;
    logic [7:0] count_a, count_b;
    logic       wrap_a, wrap_b;
    logic [6:0] seg_a, seg_b;
    logic [1:0] an_a, an_b;

    int  total = 0;
    int  bad = 0;
    int  ea, eb;
    bit  wa, wb;
    int  sc, idx;
    int  nwrap;

    bcd_counter_display #(.DIGITS(2), .TICK_DIV(1), .SCAN_DIV(SCAN_DIV), .SATURATE(0)) dut_a (
        .clk(clk), .rst(rst), .enable_i(enable_i), .dir_i(dir_i),
        .clear_i(clear_i), .load_i(load_i), .load_value_i(load_value_i),
        .count_o(count_a), .wrap_o(wrap_a), .seg_o(seg_a), .an_o(an_a)
    );

    bcd_counter_display #(.DIGITS(2), .TICK_DIV(1), .SCAN_DIV(SCAN_DIV), .SATURATE(1)) dut_b (
        .clk(clk), .rst(rst), .enable_i(enable_i), .dir_i(dir_i),
        .clear_i(clear_i), .load_i(load_i), .load_value_i(load_value_i),
        .count_o(count_b), .wrap_o(wrap_b), .seg_o(seg_b), .an_o(an_b)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: run did not finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [6:0] glyph(input int d);
        case (d)
            0: return 7'b1111110;
            1: return 7'b0110000;
            2: return 7'b1101101;
            3: return 7'b1111001;
            4: return 7'b0110011;
            5: return 7'b1011011;
            6: return 7'b1011111;
            7: return 7'b1110000;
            8: return 7'b1111111;
            9: return 7'b1111011;
            default: return 7'b0000000;
        endcase
    endfunction

    function automatic logic [7:0] to_bcd(input int v);
        logic [3:0] hi;
        logic [3:0] lo;
        hi = 4'(v / 10);
        lo = 4'(v % 10);
        return {hi, lo};
    endfunction

    function automatic logic [6:0] exp_seg(input int v, input int i);
        int d;
        d = (i == 0) ? v % 10 : v / 10;
`ifdef LEADING_ZERO_BLANK_EN
        if (i == 1 && v / 10 == 0) return 7'b0000000;
`endif
        return glyph(d);
    endfunction

    function automatic int clamp(input logic [7:0] lv);
        int hi, lo;
        hi = (lv[7:4] > 4'd9) ? 9 : int'(lv[7:4]);
        lo = (lv[3:0] > 4'd9) ? 9 : int'(lv[3:0]);
        return hi * 10 + lo;
    endfunction

    task automatic upd(inout int v, output bit w, input bit sat);
        w = 1'b0;
        if (clear_i) v = 0;
        else if (load_i) v = clamp(load_value_i);
        else if (enable_i) begin
            if (dir_i) begin
                if (v == 99) begin
                    if (!sat) begin v = 0; w = 1'b1; end
                end else v++;
            end else begin
                if (v == 0) begin
                    if (!sat) begin v = 99; w = 1'b1; end
                end else v--;
            end
        end
    endtask

    task automatic cyc();
        upd(ea, wa, 1'b0);
        upd(eb, wb, 1'b1);
        @(posedge clk);
        #1;
        if (sc == SCAN_DIV - 1) begin
            sc = 0;
            idx = (idx + 1) % 2;
        end else sc++;
        chk("cnt_a", 32'(count_a), 32'(to_bcd(ea)));
        chk("wrap_a", 32'(wrap_a), 32'(wa));
        chk("cnt_b", 32'(count_b), 32'(to_bcd(eb)));
        chk("wrap_b", 32'(wrap_b), 32'(wb));
        chk("an", 32'(an_a), 32'(1 << idx));
        chk("seg_a", 32'(seg_a), 32'(exp_seg(ea, idx)));
        chk("seg_b", 32'(seg_b), 32'(exp_seg(eb, idx)));
        if (wrap_a) nwrap++;
    endtask

    task automatic load(input logic [7:0] v);
        load_i = 1'b1;
        load_value_i = v;
        cyc();
        load_i = 1'b0;
    endtask

    initial begin
        rst = 1'b0;
        enable_i = 1'b0;
        dir_i = 1'b1;
        clear_i = 1'b0;
        load_i = 1'b0;
        load_value_i = 8'h00;
        ea = 0; eb = 0; sc = 0; idx = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_cnt", 32'(count_a), 32'h00);
        chk("rst_wrap", 32'(wrap_a), 32'h0);
        chk("rst_an", 32'(an_a), 32'h1);
        chk("rst_seg", 32'(seg_a), 32'(7'b1111110));
        @(negedge clk);
        rst = 1'b1;

        // count up through the full range and back to 00
        enable_i = 1'b1;
        dir_i = 1'b1;
        nwrap = 0;
        for (int i = 0; i < 100; i++) cyc();
        chk("up_end", 32'(count_a), 32'h00);
        chk("wrap_once", 32'(nwrap), 32'd1);

        // load 05 then count down past zero
        load(8'h05);
        dir_i = 1'b0;
        nwrap = 0;
        for (int i = 0; i < 6; i++) cyc();
        chk("dn_end", 32'(count_a), 32'h99);
        chk("dn_wrap_once", 32'(nwrap), 32'd1);

        // saturation at both limits (instance b)
        load(8'h98);
        dir_i = 1'b1;
        for (int i = 0; i < 3; i++) cyc();
        chk("sat_hi", 32'(count_b), 32'h99);
        load(8'h01);
        dir_i = 1'b0;
        for (int i = 0; i < 3; i++) cyc();
        chk("sat_lo", 32'(count_b), 32'h00);

        // clear beats load and tick; load clamps per digit
        load(8'h55);
        clear_i = 1'b1;
        load_i = 1'b1;
        load_value_i = 8'h42;
        cyc();
        chk("clr_prio", 32'(count_a), 32'h00);
        clear_i = 1'b0;
        load(8'hAF);
        chk("clamp", 32'(count_a), 32'h99);

        // hold at 37 while the scan keeps running
        load(8'h37);
        enable_i = 1'b0;
        for (int i = 0; i < 8; i++) cyc();
        chk("hold", 32'(count_a), 32'h37);

        // leading-zero candidates: 07 and 00
        load(8'h07);
        for (int i = 0; i < 4; i++) cyc();
        clear_i = 1'b1;
        cyc();
        clear_i = 1'b0;
        for (int i = 0; i < 4; i++) cyc();

        // async reset mid-scan, no clock edge needed
        load(8'h64);
        cyc();
        #2;
        rst = 1'b0;
        #1;
        chk("arst_an", 32'(an_a), 32'h1);
        chk("arst_seg", 32'(seg_a), 32'(7'b1111110));
        chk("arst_cnt", 32'(count_a), 32'h00);
        chk("arst_wrap", 32'(wrap_a), 32'h0);
        ea = 0; eb = 0; sc = 0; idx = 0;
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 5; i++) cyc();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
